mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
Memory-access pipeline stage placed directly downstream of the execute stage. It consumes the EX/MEM pipeline fields and performs loads and stores over a valid/ready data-memory port. It aligns and extends load data, raises misalignment and bus-timeout faults, and owns the MEM/WB pipeline register that feeds writeback and the WB forwarding path. It stalls upstream stages while an access is outstanding.

Parameters:
XLEN, 32, datapath and address width
REG_ADDR_WIDTH, 5, register-file index width
RSP_TIMEOUT, 64, maximum cycles spent in WAIT_RSP before an access fault is raised

Ports:
clk  in  1  single clock; all state is on its rising edge
reset  in  1  asynchronous, active-low reset
ex_valid  in  1  EX/MEM entry is valid
ex_alu_result  in  XLEN  effective address for memory ops; result value otherwise
ex_rs2_data  in  XLEN  store data, already forwarded
ex_rd_addr  in  REG_ADDR_WIDTH  destination register
ex_reg_write  in  1  instruction writes rd
ex_mem_read  in  1  load
ex_mem_write  in  1  store
ex_funct3  in  3  access size and signedness (RV32I load/store encoding)
dmem_req_valid  out  1  request valid
dmem_req_ready  in  1  memory accepts the request
dmem_addr  out  XLEN  word-aligned address ({addr[XLEN-1:2],2'b00})
dmem_we  out  1  1 = store
dmem_wstrb  out  4  byte enables
dmem_wdata  out  XLEN  lane-replicated store data
dmem_rsp_valid  in  1  load data valid
dmem_rdata  in  XLEN  load data word
mem_stall  out  1  hold EX/MEM and all upstream stages
wb_valid  out  1  MEM/WB entry is valid
wb_rd_addr  out  REG_ADDR_WIDTH  MEM/WB rd
wb_reg_write  out  1  MEM/WB write enable
wb_write_data  out  XLEN  MEM/WB writeback value
wb_exc_valid  out  1  fault on this entry
wb_exc_cause  out  2  01 load misaligned, 10 store misaligned, 11 access fault or illegal funct3
wb_exc_addr  out  XLEN  faulting effective address

Behaviour:
- Reset (reset=0, async): FSM to IDLE, timeout counter 0. Every wb_* output is 0. dmem_req_valid=0 and mem_stall=0 while reset is asserted.
- Combinational request outputs are derived from ex_* inputs. Upstream holds ex_* stable while mem_stall=1.
- FSM states are IDLE and WAIT_RSP.
- IDLE, ex_valid=0: no request; MEM/WB loads wb_valid=0.
- IDLE, non-memory op: MEM/WB loads valid, rd, reg_write and wb_write_data=ex_alu_result with a latency of 1 cycle; mem_stall=0.
- IDLE, memory op with a fault (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0; load funct3 011/110/111; store funct3 >010):
  - no request is issued;
  - MEM/WB loads wb_valid=1, wb_reg_write=0, wb_exc_valid=1, the cause and the address.
- IDLE, legal memory op: dmem_req_valid=1. mem_stall=1 until the stage completes.
  - Store: completes on the accept cycle (req_valid & req_ready). MEM/WB loads wb_reg_write=0 and mem_stall=0 in that cycle.
  - Load: on accept, go to WAIT_RSP; mem_stall stays 1.
  - ready=0: request held unchanged; no timeout.
- Store lane rules:
  - SB: wstrb=0001<<addr[1:0], wdata={4{rs2[7:0]}};
  - SH: wstrb=0011<<(2*addr[1]), wdata={2{rs2[15:0]}};
  - SW: wstrb=1111, wdata=rs2.
  - Loads drive wstrb=0000, we=0.
- WAIT_RSP: dmem_req_valid=0; counter increments each cycle.
  - On dmem_rsp_valid: select the byte/half at addr[1:0], sign-extend (LB/LH) or zero-extend (LBU/LHU), write MEM/WB, mem_stall=0 that cycle, return to IDLE, counter cleared.
  - If the counter reaches RSP_TIMEOUT-1 without a response: MEM/WB loads wb_exc_valid=1, cause 11, wb_reg_write=0; return to IDLE.
- Minimum load latency: request accepted in cycle N, data earliest in N+1, MEM/WB valid at edge N+2.
- dmem_rsp_valid while in IDLE is ignored, including late responses after a timeout or after reset.
- Reset asserted mid-WAIT_RSP abandons the access; there is no retry.
- While mem_stall=1, MEM/WB loads wb_valid=0 each cycle, inserting bubbles to writeback.
- Exactly one MEM/WB entry with wb_valid=1 is produced per valid EX/MEM instruction.

Test Plan:
- ADD result 0x1234, rd=5, ex_valid=1 -> next edge wb_valid=1, wb_rd_addr=5, wb_write_data=0x00001234, mem_stall=0 throughout.
- SB addr 0x1003, rs2=0xAABBCCDD, ready=1 -> dmem_addr=0x1000, wstrb=1000, wdata=0xDDDDDDDD, we=1, no stall; one wb_valid pulse with reg_write=0.
- LB addr 0x2002, rdata=0x00800000, rsp 3 cycles after accept -> mem_stall high 4 cycles, wb_write_data=0xFFFFFF80. LBU with the same stimulus -> 0x00000080.
- LW addr 0x3002 -> no dmem_req_valid, wb_exc_valid=1, cause=01, wb_exc_addr=0x3002, wb_reg_write=0. SH addr 0x3001 -> cause=10.
- Load accepted, no response for RSP_TIMEOUT cycles -> cause=11, stall released. A later rsp_valid is ignored, with no spurious wb_valid.
- ready=0 for 5 cycles on an SW -> request stable and stall=1 for all 5 cycles. reset pulsed while in WAIT_RSP -> all outputs 0, IDLE, and a subsequent rsp_valid is ignored.

Source files
------------

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage
// Description : Memory-access pipeline stage. Consumes the EX/MEM fields and
//               issues loads/stores over a valid/ready data-memory port. It
//               aligns and extends load data, flags misaligned and illegal
//               accesses, and times out unanswered loads. It owns the MEM/WB
//               register and stalls upstream while an access is outstanding.
// Ports       :
//   clk, reset (async, active-low)
//   ex_*       EX/MEM entry: valid, ALU result / effective address, store
//              data, rd, reg_write, mem_read, mem_write, funct3
//   dmem_*     request (valid/ready, addr, we, wstrb, wdata) and
//              response (rsp_valid, rdata)
//   mem_stall  holds EX/MEM and all upstream stages
//   wb_*       MEM/WB register: valid, rd, reg_write, data, exception info
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage #(
    parameter int XLEN           = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int RSP_TIMEOUT    = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      ex_valid,
    input  logic [XLEN-1:0]           ex_alu_result,
    input  logic [XLEN-1:0]           ex_rs2_data,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rd_addr,
    input  logic                      ex_reg_write,
    input  logic                      ex_mem_read,
    input  logic                      ex_mem_write,
    input  logic [2:0]                ex_funct3,
    output logic                      dmem_req_valid,
    input  logic                      dmem_req_ready,
    output logic [XLEN-1:0]           dmem_addr,
    output logic                      dmem_we,
    output logic [3:0]                dmem_wstrb,
    output logic [XLEN-1:0]           dmem_wdata,
    input  logic                      dmem_rsp_valid,
    input  logic [XLEN-1:0]           dmem_rdata,
    output logic                      mem_stall,
    output logic                      wb_valid,
    output logic [REG_ADDR_WIDTH-1:0] wb_rd_addr,
    output logic                      wb_reg_write,
    output logic [XLEN-1:0]           wb_write_data,
    output logic                      wb_exc_valid,
    output logic [1:0]                wb_exc_cause,
    output logic [XLEN-1:0]           wb_exc_addr
);

    localparam int                CNT_W      = $clog2(RSP_TIMEOUT) + 1;
    localparam logic [CNT_W-1:0]  C_CNT_LAST = CNT_W'(RSP_TIMEOUT - 1);
    localparam logic [1:0]        C_CAUSE_LD_MIS = 2'b01;
    localparam logic [1:0]        C_CAUSE_ST_MIS = 2'b10;
    localparam logic [1:0]        C_CAUSE_ACCESS = 2'b11;

    typedef enum logic [0:0] {
        S_IDLE     = 1'b0,
        S_WAIT_RSP = 1'b1
    } state_t;

    state_t                    r_state, w_state_nxt;
    logic [CNT_W-1:0]          r_cnt, w_cnt_nxt;

    // Load context captured on accept, used when the response arrives.
    logic [REG_ADDR_WIDTH-1:0] r_ld_rd;
    logic                      r_ld_rw;
    logic [2:0]                r_ld_f3;
    logic [XLEN-1:0]           r_ld_addr;
    logic                      w_capture;

    // MEM/WB register and its next value.
    logic                      r_wb_valid,   w_wb_valid;
    logic [REG_ADDR_WIDTH-1:0] r_wb_rd,      w_wb_rd;
    logic                      r_wb_rw,      w_wb_rw;
    logic [XLEN-1:0]           r_wb_data,    w_wb_data;
    logic                      r_wb_exc,     w_wb_exc;
    logic [1:0]                r_wb_cause,   w_wb_cause;
    logic [XLEN-1:0]           r_wb_eaddr,   w_wb_eaddr;

    logic                      w_is_load;
    logic                      w_is_store;
    logic [1:0]                w_lsb;
    logic                      w_fault;
    logic [1:0]                w_cause;
    logic                      w_req_legal;
    logic                      w_stall;
    logic [XLEN-1:0]           w_shifted;
    logic [XLEN-1:0]           w_ld_data;

    // ------------------------------------------------------------------
    // Decode and fault detection
    // ------------------------------------------------------------------
    // A set mem_read takes priority if both op flags are ever raised.
    assign w_is_load  = ex_valid & ex_mem_read;
    assign w_is_store = ex_valid & ex_mem_write & ~ex_mem_read;
    assign w_lsb      = ex_alu_result[1:0];

    always_comb begin
        w_fault = 1'b0;
        w_cause = 2'b00;
        if (w_is_load) begin
            case (ex_funct3)
                3'b000, 3'b100: ;
                3'b001, 3'b101: begin
                    w_fault = w_lsb[0];
                    w_cause = C_CAUSE_LD_MIS;
                end
                3'b010: begin
                    w_fault = (w_lsb != 2'b00);
                    w_cause = C_CAUSE_LD_MIS;
                end
                default: begin
                    w_fault = 1'b1;
                    w_cause = C_CAUSE_ACCESS;
                end
            endcase
        end else if (w_is_store) begin
            case (ex_funct3)
                3'b000: ;
                3'b001: begin
                    w_fault = w_lsb[0];
                    w_cause = C_CAUSE_ST_MIS;
                end
                3'b010: begin
                    w_fault = (w_lsb != 2'b00);
                    w_cause = C_CAUSE_ST_MIS;
                end
                default: begin
                    w_fault = 1'b1;
                    w_cause = C_CAUSE_ACCESS;
                end
            endcase
        end
    end

    assign w_req_legal = (w_is_load | w_is_store) & ~w_fault;

    // ------------------------------------------------------------------
    // Request port (combinational from EX/MEM, which is held during stall)
    // ------------------------------------------------------------------
    assign dmem_req_valid = reset & (r_state == S_IDLE) & w_req_legal;
    assign dmem_addr      = {ex_alu_result[XLEN-1:2], 2'b00};
    assign dmem_we        = w_is_store;

    always_comb begin
        dmem_wstrb = 4'b0000;
        dmem_wdata = ex_rs2_data;
        if (w_is_store) begin
            case (ex_funct3[1:0])
                2'b00: begin
                    dmem_wstrb = 4'b0001 << w_lsb;
                    dmem_wdata = XLEN'({4{ex_rs2_data[7:0]}});
                end
                2'b01: begin
                    dmem_wstrb = w_lsb[1] ? 4'b1100 : 4'b0011;
                    dmem_wdata = XLEN'({2{ex_rs2_data[15:0]}});
                end
                default: begin
                    dmem_wstrb = 4'b1111;
                    dmem_wdata = ex_rs2_data;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Load data alignment and extension
    // ------------------------------------------------------------------
    assign w_shifted = dmem_rdata >> {r_ld_addr[1:0], 3'b000};

    always_comb begin
        case (r_ld_f3)
            3'b000:  w_ld_data = {{(XLEN-8){w_shifted[7]}},   w_shifted[7:0]};
            3'b001:  w_ld_data = {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
            3'b100:  w_ld_data = {{(XLEN-8){1'b0}},           w_shifted[7:0]};
            3'b101:  w_ld_data = {{(XLEN-16){1'b0}},          w_shifted[15:0]};
            default: w_ld_data = w_shifted;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM next-state, stall and MEM/WB next value. MEM/WB defaults to a
    // bubble; every branch that completes an instruction overrides it.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_stall     = 1'b0;
        w_capture   = 1'b0;
        w_wb_valid  = 1'b0;
        w_wb_rd     = '0;
        w_wb_rw     = 1'b0;
        w_wb_data   = '0;
        w_wb_exc    = 1'b0;
        w_wb_cause  = 2'b00;
        w_wb_eaddr  = '0;

        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (ex_valid) begin
                    if (!(w_is_load || w_is_store)) begin
                        w_wb_valid = 1'b1;
                        w_wb_rd    = ex_rd_addr;
                        w_wb_rw    = ex_reg_write;
                        w_wb_data  = ex_alu_result;
                    end else if (w_fault) begin
                        w_wb_valid = 1'b1;
                        w_wb_rd    = ex_rd_addr;
                        w_wb_exc   = 1'b1;
                        w_wb_cause = w_cause;
                        w_wb_eaddr = ex_alu_result;
                    end else if (w_is_store) begin
                        if (dmem_req_ready) begin
                            w_wb_valid = 1'b1;
                            w_wb_rd    = ex_rd_addr;
                        end else begin
                            w_stall = 1'b1;
                        end
                    end else begin
                        w_stall = 1'b1;
                        if (dmem_req_ready) begin
                            w_capture   = 1'b1;
                            w_state_nxt = S_WAIT_RSP;
                        end
                    end
                end
            end

            S_WAIT_RSP: begin
                if (dmem_rsp_valid) begin
                    w_wb_valid  = 1'b1;
                    w_wb_rd     = r_ld_rd;
                    w_wb_rw     = r_ld_rw;
                    w_wb_data   = w_ld_data;
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == C_CNT_LAST) begin
                    // Release the stall this cycle so the faulting load
                    // retires instead of being re-issued from IDLE.
                    w_wb_valid  = 1'b1;
                    w_wb_rd     = r_ld_rd;
                    w_wb_exc    = 1'b1;
                    w_wb_cause  = C_CAUSE_ACCESS;
                    w_wb_eaddr  = r_ld_addr;
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_stall   = 1'b1;
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign mem_stall = reset & w_stall;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ld_rd   <= '0;
            r_ld_rw   <= 1'b0;
            r_ld_f3   <= 3'b000;
            r_ld_addr <= '0;
        end else if (w_capture) begin
            r_ld_rd   <= ex_rd_addr;
            r_ld_rw   <= ex_reg_write;
            r_ld_f3   <= ex_funct3;
            r_ld_addr <= ex_alu_result;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wb_valid <= 1'b0;
            r_wb_rd    <= '0;
            r_wb_rw    <= 1'b0;
            r_wb_data  <= '0;
            r_wb_exc   <= 1'b0;
            r_wb_cause <= 2'b00;
            r_wb_eaddr <= '0;
        end else begin
            r_wb_valid <= w_wb_valid;
            r_wb_rd    <= w_wb_rd;
            r_wb_rw    <= w_wb_rw;
            r_wb_data  <= w_wb_data;
            r_wb_exc   <= w_wb_exc;
            r_wb_cause <= w_wb_cause;
            r_wb_eaddr <= w_wb_eaddr;
        end
    end

    assign wb_valid      = r_wb_valid;
    assign wb_rd_addr    = r_wb_rd;
    assign wb_reg_write  = r_wb_rw;
    assign wb_write_data = r_wb_data;
    assign wb_exc_valid  = r_wb_exc;
    assign wb_exc_cause  = r_wb_cause;
    assign wb_exc_addr   = r_wb_eaddr;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage
// Description : Self-checking bench for mem_stage. Single-cycle operations
//               are applied from a vector table; loads, timeouts, request
//               back-pressure and reset during an access are hand sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

    localparam int C_TIMEOUT = 64;

    logic        clk;
    logic        reset;
    logic        ex_valid;
    logic [31:0] ex_alu_result;
    logic [31:0] ex_rs2_data;
    logic [4:0]  ex_rd_addr;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic [2:0]  ex_funct3;
    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic [31:0] dmem_addr;
    logic        dmem_we;
    logic [3:0]  dmem_wstrb;
    logic [31:0] dmem_wdata;
    logic        dmem_rsp_valid;
    logic [31:0] dmem_rdata;
    logic        mem_stall;
    logic        wb_valid;
    logic [4:0]  wb_rd_addr;
    logic        wb_reg_write;
    logic [31:0] wb_write_data;
    logic        wb_exc_valid;
    logic [1:0]  wb_exc_cause;
    logic [31:0] wb_exc_addr;

    int passed = 0;
    int total  = 0;

    mem_stage #(
        .XLEN           (32),
        .REG_ADDR_WIDTH (5),
        .RSP_TIMEOUT    (C_TIMEOUT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .ex_valid       (ex_valid),
        .ex_alu_result  (ex_alu_result),
        .ex_rs2_data    (ex_rs2_data),
        .ex_rd_addr     (ex_rd_addr),
        .ex_reg_write   (ex_reg_write),
        .ex_mem_read    (ex_mem_read),
        .ex_mem_write   (ex_mem_write),
        .ex_funct3      (ex_funct3),
        .dmem_req_valid (dmem_req_valid),
        .dmem_req_ready (dmem_req_ready),
        .dmem_addr      (dmem_addr),
        .dmem_we        (dmem_we),
        .dmem_wstrb     (dmem_wstrb),
        .dmem_wdata     (dmem_wdata),
        .dmem_rsp_valid (dmem_rsp_valid),
        .dmem_rdata     (dmem_rdata),
        .mem_stall      (mem_stall),
        .wb_valid       (wb_valid),
        .wb_rd_addr     (wb_rd_addr),
        .wb_reg_write   (wb_reg_write),
        .wb_write_data  (wb_write_data),
        .wb_exc_valid   (wb_exc_valid),
        .wb_exc_cause   (wb_exc_cause),
        .wb_exc_addr    (wb_exc_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        valid;
        logic [31:0] alu;
        logic [31:0] rs2;
        logic [4:0]  rd;
        logic        rw;
        logic        mrd;
        logic        mwr;
        logic [2:0]  f3;
        logic        e_req;
        logic [31:0] e_daddr;
        logic [3:0]  e_wstrb;
        logic [31:0] e_wdata;
        logic        e_stall;
        logic        e_wbv;
        logic        e_rw;
        logic [31:0] e_data;
        logic        e_exc;
        logic [1:0]  e_cause;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        else
            passed++;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ex_valid     = 1'b0;
        ex_mem_read  = 1'b0;
        ex_mem_write = 1'b0;
        ex_reg_write = 1'b0;
        ex_funct3    = 3'b000;
    endtask

    task automatic drive_load(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd);
        ex_valid      = 1'b1;
        ex_mem_read   = 1'b1;
        ex_mem_write  = 1'b0;
        ex_reg_write  = 1'b1;
        ex_rd_addr    = rd;
        ex_alu_result = addr;
        ex_rs2_data   = 32'h0;
        ex_funct3     = f3;
    endtask

    // Load with `waits` response-free cycles in WAIT_RSP before the response.
    task automatic do_load(input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] rdata, input int waits,
                           input logic [31:0] exp, input string nm);
        int stall_cnt;
        stall_cnt = 0;
        drive_load(f3, addr, 5'd7);
        dmem_req_ready = 1'b1;
        dmem_rsp_valid = 1'b0;
        dmem_rdata     = 32'h0;
        #1;
        chk({nm, "_req"},   {dmem_req_valid, dmem_we, dmem_wstrb}, {1'b1, 1'b0, 4'b0000});
        chk({nm, "_daddr"}, dmem_addr, addr & 32'hFFFF_FFFC);
        if (mem_stall) stall_cnt++;
        next_cycle();
        dmem_req_ready = 1'b0;
        for (int w = 0; w < waits; w++) begin
            #1;
            if (mem_stall) stall_cnt++;
            if (dmem_req_valid || wb_valid)
                chk({nm, "_wait_quiet"}, {dmem_req_valid, wb_valid}, 2'b00);
            next_cycle();
        end
        dmem_rsp_valid = 1'b1;
        dmem_rdata     = rdata;
        #1;
        chk({nm, "_rsp_stall"}, mem_stall, 1'b0);
        next_cycle();
        dmem_rsp_valid = 1'b0;
        idle_inputs();
        chk({nm, "_wb"}, {wb_valid, wb_reg_write, wb_exc_valid, wb_rd_addr}, {1'b1, 1'b1, 1'b0, 5'd7});
        chk({nm, "_data"}, wb_write_data, exp);
        chk({nm, "_stall_cycles"}, stall_cnt, waits + 1);
        next_cycle();
        chk({nm, "_single_entry"}, wb_valid, 1'b0);
    endtask

    initial begin
        int waits;
        logic bad;

        //               valid alu           rs2           rd    rw    mrd   mwr   f3      req   daddr         wstrb    wdata         stall wbv   rw    data          exc   cause
        vecs[0]  = '{1'b1, 32'h0000_1234, 32'h0,        5'd5, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 32'h0,        4'b0000, 32'h0,        1'b0, 1'b1, 1'b1, 32'h0000_1234, 1'b0, 2'b00};
        vecs[1]  = '{1'b1, 32'h0000_1003, 32'hAABBCCDD, 5'd1, 1'b0, 1'b0, 1'b1, 3'b000, 1'b1, 32'h0000_1000, 4'b1000, 32'hDDDDDDDD, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 2'b00};
        vecs[2]  = '{1'b1, 32'h0000_2002, 32'h11223344, 5'd1, 1'b0, 1'b0, 1'b1, 3'b001, 1'b1, 32'h0000_2000, 4'b1100, 32'h33443344, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 2'b00};
        vecs[3]  = '{1'b1, 32'h0000_2004, 32'hCAFEBABE, 5'd1, 1'b0, 1'b0, 1'b1, 3'b010, 1'b1, 32'h0000_2004, 4'b1111, 32'hCAFEBABE, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 2'b00};
        vecs[4]  = '{1'b1, 32'h0000_3002, 32'h0,        5'd2, 1'b1, 1'b1, 1'b0, 3'b010, 1'b0, 32'h0,        4'b0000, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 2'b01};
        vecs[5]  = '{1'b1, 32'h0000_3001, 32'h0000FFFF, 5'd0, 1'b0, 1'b0, 1'b1, 3'b001, 1'b0, 32'h0,        4'b0000, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 2'b10};
        vecs[6]  = '{1'b1, 32'h0000_4000, 32'h0,        5'd3, 1'b1, 1'b1, 1'b0, 3'b011, 1'b0, 32'h0,        4'b0000, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 2'b11};
        vecs[7]  = '{1'b1, 32'h0000_4004, 32'h0,        5'd0, 1'b0, 1'b0, 1'b1, 3'b100, 1'b0, 32'h0,        4'b0000, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 2'b11};
        vecs[8]  = '{1'b0, 32'h0000_DEAD, 32'h0,        5'd4, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 32'h0,        4'b0000, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 2'b00};
        vecs[9]  = '{1'b1, 32'h0000_5003, 32'h0,        5'd6, 1'b1, 1'b1, 1'b0, 3'b101, 1'b0, 32'h0,        4'b0000, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 2'b01};
        vecs[10] = '{1'b1, 32'h0000_1000, 32'h00000012, 5'd1, 1'b0, 1'b0, 1'b1, 3'b000, 1'b1, 32'h0000_1000, 4'b0001, 32'h12121212, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 2'b00};
        vecs[11] = '{1'b1, 32'h0000_6001, 32'h0,        5'd1, 1'b0, 1'b0, 1'b1, 3'b010, 1'b0, 32'h0,        4'b0000, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 2'b10};
        vecs[12] = '{1'b1, 32'hFFFF_FFFF, 32'h0,        5'd9, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 32'h0,        4'b0000, 32'h0,        1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0, 2'b00};

        // ---- reset: a legal store is presented, outputs must stay quiet ----
        reset          = 1'b1;
        ex_valid       = 1'b1;
        ex_alu_result  = 32'h0000_0100;
        ex_rs2_data    = 32'h1234_5678;
        ex_rd_addr     = 5'd1;
        ex_reg_write   = 1'b0;
        ex_mem_read    = 1'b0;
        ex_mem_write   = 1'b1;
        ex_funct3      = 3'b010;
        dmem_req_ready = 1'b1;
        dmem_rsp_valid = 1'b0;
        dmem_rdata     = 32'h0;
        #2 reset = 1'b0;
        next_cycle();
        next_cycle();
        chk("rst_req_stall", {dmem_req_valid, mem_stall}, 2'b00);
        chk("rst_wb", {wb_valid, wb_rd_addr, wb_reg_write, wb_write_data, wb_exc_valid, wb_exc_cause, wb_exc_addr}, 64'h0);
        reset = 1'b1;
        idle_inputs();
        next_cycle();

        // ---- single-cycle vector table ----
        for (int i = 0; i < 13; i++) begin
            ex_valid       = vecs[i].valid;
            ex_alu_result  = vecs[i].alu;
            ex_rs2_data    = vecs[i].rs2;
            ex_rd_addr     = vecs[i].rd;
            ex_reg_write   = vecs[i].rw;
            ex_mem_read    = vecs[i].mrd;
            ex_mem_write   = vecs[i].mwr;
            ex_funct3      = vecs[i].f3;
            dmem_req_ready = 1'b1;
            #1;
            chk($sformatf("v%0d_req", i), dmem_req_valid, vecs[i].e_req);
            if (vecs[i].e_req) begin
                chk($sformatf("v%0d_daddr", i), dmem_addr, vecs[i].e_daddr);
                chk($sformatf("v%0d_we", i), dmem_we, 1'b1);
                chk($sformatf("v%0d_wstrb", i), dmem_wstrb, vecs[i].e_wstrb);
                chk($sformatf("v%0d_wdata", i), dmem_wdata, vecs[i].e_wdata);
            end
            chk($sformatf("v%0d_stall", i), mem_stall, vecs[i].e_stall);
            next_cycle();
            chk($sformatf("v%0d_wbv", i), wb_valid, vecs[i].e_wbv);
            if (vecs[i].e_wbv) begin
                chk($sformatf("v%0d_rw", i), wb_reg_write, vecs[i].e_rw);
                chk($sformatf("v%0d_exc", i), wb_exc_valid, vecs[i].e_exc);
                if (vecs[i].e_exc) begin
                    chk($sformatf("v%0d_cause", i), wb_exc_cause, vecs[i].e_cause);
                    chk($sformatf("v%0d_eaddr", i), wb_exc_addr, vecs[i].alu);
                end else begin
                    chk($sformatf("v%0d_rd", i), wb_rd_addr, vecs[i].rd);
                    chk($sformatf("v%0d_data", i), wb_write_data, vecs[i].e_data);
                end
            end
        end
        idle_inputs();
        next_cycle();

        // ---- loads: extension, lane select, minimum latency ----
        do_load(3'b000, 32'h0000_2002, 32'h0080_0000, 3, 32'hFFFF_FF80, "lb");
        do_load(3'b100, 32'h0000_2002, 32'h0080_0000, 3, 32'h0000_0080, "lbu");
        do_load(3'b001, 32'h0000_2002, 32'hBEEF_0000, 0, 32'hFFFF_BEEF, "lh");
        do_load(3'b101, 32'h0000_2002, 32'hBEEF_0000, 0, 32'h0000_BEEF, "lhu");
        do_load(3'b010, 32'h0000_2008, 32'h8765_4321, 1, 32'h8765_4321, "lw");

        // ---- timeout: no response ever arrives ----
        drive_load(3'b010, 32'h0000_6000, 5'd8);
        dmem_req_ready = 1'b1;
        dmem_rsp_valid = 1'b0;
        #1;
        chk("to_req", dmem_req_valid, 1'b1);
        next_cycle();
        dmem_req_ready = 1'b0;
        waits = 0;
        bad   = 1'b0;
        for (int k = 0; k < 200; k++) begin
            #1;
            if (!mem_stall) break;
            if (wb_valid || dmem_req_valid) bad = 1'b1;
            waits++;
            next_cycle();
        end
        chk("to_wait_cycles", waits, C_TIMEOUT - 1);
        chk("to_quiet", bad, 1'b0);
        next_cycle();
        idle_inputs();
        chk("to_wb", {wb_valid, wb_reg_write, wb_exc_valid, wb_exc_cause}, {1'b1, 1'b0, 1'b1, 2'b11});
        chk("to_eaddr", wb_exc_addr, 32'h0000_6000);
        dmem_rsp_valid = 1'b1;
        dmem_rdata     = 32'h5555_5555;
        next_cycle();
        chk("late_rsp_0", {wb_valid, mem_stall, dmem_req_valid}, 3'b000);
        next_cycle();
        chk("late_rsp_1", {wb_valid, mem_stall, dmem_req_valid}, 3'b000);
        dmem_rsp_valid = 1'b0;

        // ---- store back-pressure: request held for 5 cycles ----
        ex_valid       = 1'b1;
        ex_alu_result  = 32'h0000_7008;
        ex_rs2_data    = 32'h0BAD_F00D;
        ex_rd_addr     = 5'd2;
        ex_reg_write   = 1'b0;
        ex_mem_read    = 1'b0;
        ex_mem_write   = 1'b1;
        ex_funct3      = 3'b010;
        dmem_req_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk($sformatf("bp%0d_req", c), {dmem_req_valid, dmem_we, dmem_wstrb, mem_stall}, {1'b1, 1'b1, 4'b1111, 1'b1});
            chk($sformatf("bp%0d_addr_data", c), {dmem_addr, dmem_wdata}, {32'h0000_7008, 32'h0BAD_F00D});
            next_cycle();
            chk($sformatf("bp%0d_bubble", c), wb_valid, 1'b0);
        end
        dmem_req_ready = 1'b1;
        #1;
        chk("bp_accept_stall", mem_stall, 1'b0);
        next_cycle();
        idle_inputs();
        chk("bp_wb", {wb_valid, wb_reg_write, wb_exc_valid}, 3'b100);

        // ---- reset during WAIT_RSP abandons the load ----
        drive_load(3'b010, 32'h0000_8000, 5'd10);
        dmem_req_ready = 1'b1;
        next_cycle();
        dmem_req_ready = 1'b0;
        next_cycle();
        reset = 1'b0;
        #1;
        chk("mid_rst_out", {dmem_req_valid, mem_stall, wb_valid, wb_reg_write, wb_exc_valid}, 5'b00000);
        next_cycle();
        reset = 1'b1;
        idle_inputs();
        dmem_rsp_valid = 1'b1;
        dmem_rdata     = 32'h0000_0123;
        #1;
        chk("mid_rst_idle_stall", mem_stall, 1'b0);
        next_cycle();
        chk("mid_rst_late_rsp", wb_valid, 1'b0);
        dmem_rsp_valid = 1'b0;
        ex_valid       = 1'b1;
        ex_alu_result  = 32'h0000_0055;
        ex_rd_addr     = 5'd3;
        ex_reg_write   = 1'b1;
        next_cycle();
        idle_inputs();
        chk("post_rst_alu", {wb_valid, wb_rd_addr, wb_write_data}, {1'b1, 5'd3, 32'h0000_0055});

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
